// File: rtl/out_fsm_pkg.sv
// Shared definitions for the frame transmitter: header byte, FSM state
// encoding and the frame checksum function.
package out_fsm_pkg;

    // Frame header byte recognised by the receiving end.
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_HDR     = 3'd2,
        ST_LEN     = 3'd3,
        ST_DATA    = 3'd4,
        ST_CSUM    = 3'd5
    } state_t;

    // Checksum byte chosen so that LEN + payload + CSUM == 0 (mod 256).
    function automatic logic [7:0] csum8(input logic [7:0] len, input logic [7:0] sum);
        return 8'h00 - len - sum;
    endfunction

endpackage

// File: rtl/out_fsm_if.sv
// Byte-stream bundle around the frame transmitter.
//   in_data/in_valid/in_last/in_ready : payload input stream
//   out_data/out_valid/out_ready/out_sof : framed output stream
// master: the environment (payload source and frame sink)
// slave : the transmitter itself
interface out_fsm_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_sof
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_sof
    );

endinterface

// File: rtl/out_fsm_byte_buf.sv
// Payload buffer for one frame.
//   clk     : clock
//   wr_en   : write wr_data at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
// The controller never writes and reads in the same cycle, so there is no
// read-during-write case to resolve. Contents need no reset: only bytes
// written for the current frame are ever read.
module byte_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/out_fsm.sv
// Frame transmitter: buffers one payload from the input byte stream, then
// emits HDR, LEN, payload, CSUM on the output byte stream.
//   clk      : clock, all logic on posedge
//   rst_a    : synchronous reset, active low
//   ena      : enable, only looked at in IDLE
//   bus      : payload input stream and framed output stream (slave side)
//   busy     : high whenever the FSM is not in IDLE
//   err_ovf  : one-cycle pulse when a frame is force-closed at MAX_LEN
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for first payload byte (accepted only when ena=1)
// COLLECT | storing payload bytes until in_last or MAX_LEN reached
// HDR     | presenting header byte, out_sof high
// LEN     | presenting payload length
// DATA    | presenting buffered payload bytes in order
// CSUM    | presenting checksum, then back to IDLE
module out_fsm
    import out_fsm_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF,
    parameter int         MAX_LEN  = 16,
    parameter int         ADDR_W   = $clog2(MAX_LEN)
) (
    input  logic      clk,
    input  logic      rst_a,
    input  logic      ena,
    out_fsm_if.slave  bus,
    output logic      busy,
    output logic      err_ovf
);

    // One extra bit so cnt can hold MAX_LEN itself.
    localparam int CNT_W = ADDR_W + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         sum_q, sum_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic               err_ovf_q, err_ovf_d;

    logic               in_ready_c;
    logic               out_valid_c;
    logic [7:0]         out_data_c;
    logic               out_sof_c;
    logic               wr_en;
    logic               in_acc;
    logic               out_tx;
    logic [7:0]         rd_data;

    // Write address is the count of bytes already stored in this frame.
    byte_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt_q[ADDR_W-1:0]),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sum_q     <= '0;
            rd_ptr_q  <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            rd_ptr_q  <= rd_ptr_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        rd_ptr_d    = rd_ptr_q;
        err_ovf_d   = 1'b0;
        wr_en       = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = 8'h00;
        out_sof_c   = 1'b0;

        // Handshake outputs come from state (and ena) only; the inputs of the
        // other party are consumed below, never fed back to these outputs.
        unique case (state_q)
            ST_IDLE:    in_ready_c = ena;
            ST_COLLECT: in_ready_c = 1'b1;
            ST_HDR: begin
                out_valid_c = 1'b1;
                out_data_c  = HDR_BYTE;
                out_sof_c   = 1'b1;
            end
            ST_LEN: begin
                out_valid_c = 1'b1;
                out_data_c  = 8'(cnt_q);
            end
            ST_DATA: begin
                out_valid_c = 1'b1;
                out_data_c  = rd_data;
            end
            ST_CSUM: begin
                out_valid_c = 1'b1;
                out_data_c  = csum8(8'(cnt_q), sum_q);
            end
            default: ;
        endcase

        in_acc = bus.in_valid & in_ready_c;
        out_tx = out_valid_c & bus.out_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (in_acc) begin
                    wr_en   = 1'b1;
                    cnt_d   = CNT_W'(1);
                    sum_d   = bus.in_data;
                    state_d = bus.in_last ? ST_HDR : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (in_acc) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    sum_d = sum_q + bus.in_data;
                    if (bus.in_last) begin
                        state_d = ST_HDR;
                    end else if (cnt_q == CNT_W'(MAX_LEN - 1)) begin
                        // Buffer full without in_last: close the frame here,
                        // the next byte offered starts a new frame.
                        state_d   = ST_HDR;
                        err_ovf_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (out_tx) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (out_tx) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (out_tx) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    if (CNT_W'(rd_ptr_q) + CNT_W'(1) == cnt_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (out_tx) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    sum_d    = '0;
                    rd_ptr_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_sof   = out_sof_c;
    assign busy          = (state_q != ST_IDLE);
    assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_out_fsm.sv
// Directed bench for the frame transmitter.
module tb_out_fsm;

    logic clk = 1'b0;
    logic rst_a;
    logic ena;
    logic busy;
    logic err_ovf;

    out_fsm_if bus();

    out_fsm #(
        .HDR_BYTE (8'hA5),
        .MAX_LEN  (16)
    ) dut (
        .clk     (clk),
        .rst_a   (rst_a),
        .ena     (ena),
        .bus     (bus.slave),
        .busy    (busy),
        .err_ovf (err_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int         beat_idx   = 0;
    int         frame_len  = 0;
    int         stall_cnt  = 0;
    int         rdy_toggle = 0;
    logic       stall_seen = 1'b0;
    logic [7:0] stall_data;
    logic       stall_sof;

    // Output monitor: sampled on the falling edge, so valid & ready here
    // means a transfer on the next rising edge.
    always @(negedge clk) begin
        if (rst_a && bus.out_valid) begin
            if (stall_seen) begin
                chk("stall_data", bus.out_data, stall_data);
                chk("stall_sof", bus.out_sof, stall_sof);
            end
            chk("sof", bus.out_sof, beat_idx == 0);
            if (bus.out_ready) begin
                cap_q.push_back(bus.out_data);
                if (beat_idx == 1) frame_len = bus.out_data;
                beat_idx++;
                if (beat_idx == frame_len + 3) beat_idx = 0;
                stall_seen = 1'b0;
            end else begin
                stall_seen = 1'b1;
                stall_data = bus.out_data;
                stall_sof  = bus.out_sof;
                stall_cnt++;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_toggle == 0) bus.out_ready = 1'b1;
        else                 bus.out_ready = ~bus.out_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (cap_q.size() < exp_q.size() && n < 500) begin
            tick();
            n++;
        end
        chk({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hDEAD, exp_q[i]);
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic send_case2();
        exp_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        ena           = 1'b0;
        rst_a         = 1'b0;
        repeat (3) tick();

        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sof", bus.out_sof, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_ovf", err_ovf, 0);

        rst_a = 1'b1;
        tick();
        ena = 1'b1;

        // 1: single-byte frame
        exp_q = '{8'hA5, 8'h01, 8'h10, 8'hEF};
        send(8'h10, 1'b1);
        chk("t1_lat_valid", bus.out_valid, 1);
        chk("t1_lat_data", bus.out_data, 8'hA5);
        wait_frame("t1");
        repeat (2) tick();
        chk("t1_busy", busy, 0);

        // 2: three-byte frame
        send_case2();
        wait_frame("t2");
        repeat (2) tick();

        // 3: same frame with out_ready toggling
        rdy_toggle = 1;
        stall_cnt  = 0;
        send_case2();
        wait_frame("t3");
        chk("t3_stalls_seen", stall_cnt > 0, 1);
        rdy_toggle = 0;
        repeat (3) tick();

        // 4: overflow at MAX_LEN
        exp_q = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h78};
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0);
            chk($sformatf("t4_ovf_%0d", i), err_ovf, i == 15);
        end
        chk("t4_in_ready_full", bus.in_ready, 0);
        tick();
        chk("t4_ovf_pulse_end", err_ovf, 0);
        chk("t4_in_ready_stall", bus.in_ready, 0);
        send(8'h10, 1'b0);
        wait_frame("t4");
        chk("t4_next_busy", busy, 1);
        chk("t4_next_ovf", err_ovf, 0);
        exp_q = '{8'hA5, 8'h02, 8'h10, 8'h11, 8'hDD};
        send(8'h11, 1'b1);
        wait_frame("t4b");
        repeat (2) tick();

        // 5: enable handling
        ena          = 1'b0;
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_in_ready_off", bus.in_ready, 0);
            chk("t5_busy_off", busy, 0);
        end
        bus.in_valid = 1'b0;
        ena = 1'b1;
        exp_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
        send(8'h01, 1'b0);
        ena = 1'b0;
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        wait_frame("t5");
        repeat (2) tick();
        chk("t5_idle_in_ready", bus.in_ready, 0);
        ena = 1'b1;

        // 6: reset while emitting payload
        send_case2();
        begin
            int n = 0;
            while (cap_q.size() < 3 && n < 100) begin
                tick();
                n++;
            end
            chk("t6_reach_data", cap_q.size() >= 3, 1);
        end
        rst_a = 1'b0;
        tick();
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_out_data", bus.out_data, 0);
        chk("t6_rst_out_sof", bus.out_sof, 0);
        rst_a = 1'b1;
        cap_q.delete();
        exp_q.delete();
        beat_idx   = 0;
        stall_seen = 1'b0;
        repeat (5) tick();
        chk("t6_no_residue", cap_q.size(), 0);
        send_case2();
        wait_frame("t6");
        repeat (2) tick();
        chk("t6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
